// File: rtl/clk_period_meter_pkg.sv
// Shared definitions for the clock period meter.
//   CLK_IN_HZ    : frequency of the sampling clock.
//   DEF_CNT_W    : default counter / measurement width.
//   DEF_TIMEOUT  : default loss-of-signal limit, 100 ms of CLK_IN_HZ.
//   state_e      : measurement FSM encoding.
package clk_period_meter_pkg;

    localparam int unsigned CLK_IN_HZ   = 25_000_000;
    localparam int unsigned DEF_CNT_W   = 24;
    localparam int unsigned DEF_TIMEOUT = CLK_IN_HZ / 10;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser followed by a previous-value flop, for bringing a
// slow asynchronous level into the clk_i domain and spotting its edges.
//   clk_i   : sampling clock
//   rst_ni  : asynchronous active-low reset, clears all three flops
//   async_i : asynchronous input level
//   rise_o  : combinational, high for one cycle per synchronised rising edge
//   fall_o  : combinational, high for one cycle per synchronised falling edge
module sync_edge_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise_o = sync2_q & ~prev_q;
    assign fall_o = ~sync2_q & prev_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures a slow square wave sampled in the clk_in domain: emits clean
// edge ticks, reports period and high time in clk_in cycles, and flags
// loss of signal when no rising edge is seen for TIMEOUT cycles.
//   clk_in       : sampling clock, all logic on posedge
//   rst_n        : asynchronous active-low reset
//   sig_in       : slow square wave, asynchronous to clk_in
//   rise_tick    : one-cycle pulse per synchronised rising edge
//   fall_tick    : one-cycle pulse per synchronised falling edge
//   period       : cycles between the last two rising edges (held)
//   high_time    : cycles rise->fall of the last complete period (held)
//   period_valid : one-cycle pulse when period/high_time update
//   timeout      : level, high while the signal is considered lost
module clk_period_meter
    import clk_period_meter_pkg::*;
#(
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic             rise_tick,
    output logic             fall_tick,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             timeout
);

    // The counter never runs past TIMEOUT, so it must be representable.
    if (TIMEOUT == 0 || 64'(TIMEOUT) >= (64'd1 << CNT_W)) begin : g_bad_timeout
        $error("clk_period_meter: TIMEOUT must lie in 1 .. 2**CNT_W-1");
    end

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic rise;
    logic fall;

    sync_edge_detect u_sync (
        .clk_i   (clk_in),
        .rst_ni  (rst_n),
        .async_i (sig_in),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             pv_q, pv_d;
    logic             to_q, to_d;
    logic             rise_q, fall_q;
    logic             at_limit;

    assign at_limit = (cnt_q == LIMIT);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_cnt_d = hi_cnt_q;
        period_d = period_q;
        high_d   = high_q;
        pv_d     = 1'b0;
        to_d     = to_q;

        unique case (state_q)
            ST_IDLE: begin
                // No reference edge yet: the first rise only starts counting.
                cnt_d = '0;
                if (rise) begin
                    state_d = ST_MEASURE;
                    cnt_d   = ONE;
                    to_d    = 1'b0;
                end
            end
            ST_MEASURE: begin
                // A rise landing on the limit cycle still closes a valid period.
                if (rise) begin
                    cnt_d    = ONE;
                    period_d = cnt_q;
                    high_d   = hi_cnt_q;
                    pv_d     = 1'b1;
                    to_d     = 1'b0;
                end else if (at_limit) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    to_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
                if (fall) begin
                    hi_cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hi_cnt_q <= '0;
            period_q <= '0;
            high_q   <= '0;
            pv_q     <= 1'b0;
            to_q     <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_cnt_q <= hi_cnt_d;
            period_q <= period_d;
            high_q   <= high_d;
            pv_q     <= pv_d;
            to_q     <= to_d;
            rise_q   <= rise;
            fall_q   <= fall;
        end
    end

    assign rise_tick    = rise_q;
    assign fall_tick    = fall_q;
    assign period       = period_q;
    assign high_time    = high_q;
    assign period_valid = pv_q;
    assign timeout      = to_q;

endmodule
